// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter type, stepper states and rotor notch constants
package enigma_pkg;
  localparam int ALPHA_SIZE = 26;
  typedef logic [4:0] letter_t;
  localparam letter_t ALPHA_LAST = letter_t'(ALPHA_SIZE - 1);
  typedef enum logic [1:0] {IDLE, STEP, OUT} step_state_t;
  localparam letter_t NOTCH_I   = 5'd16;
  localparam letter_t NOTCH_II  = 5'd4;
  localparam letter_t NOTCH_III = 5'd21;
  localparam letter_t NOTCH_IV  = 5'd9;
  localparam letter_t NOTCH_V   = 5'd25;
  // Operator codes above Z wrap back into the alphabet instead of being rejected.
  function automatic letter_t fold(letter_t v);
    return (v > ALPHA_LAST) ? v - letter_t'(ALPHA_SIZE) : v;
  endfunction
endpackage

// File: rtl/rotor_counter.sv
// rotor_counter: mod-26 rotor position register with load, step and notch detect
module rotor_counter
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH = 5'd0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  letter_t load_val,
  input  logic    step_en,
  output letter_t pos,
  output logic    at_notch
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pos <= '0;
    else if (load) pos <= fold(load_val);
    else if (step_en) pos <= (pos == ALPHA_LAST) ? '0 : pos + 5'd1;
  assign at_notch = (pos == NOTCH);
endmodule

// File: rtl/rotor_stepper.sv
// rotor_stepper: per-keystroke Enigma rotor stepping with double step and output handshake
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH1 = NOTCH_III,
  parameter letter_t NOTCH2 = NOTCH_II,
  parameter letter_t NOTCH3 = NOTCH_I
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_load,
  input  logic [4:0] cfg_pos1,
  input  logic [4:0] cfg_pos2,
  input  logic [4:0] cfg_pos3,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [4:0] key_char,
  output logic       char_valid,
  input  logic       char_ready,
  output logic [4:0] char_out,
  output logic [4:0] pos1,
  output logic [4:0] pos2,
  output logic [4:0] pos3
);
  step_state_t state;
  logic legal, load, stp, n1, n2;
  assign key_ready = (state == IDLE) && !cfg_load;
  assign load = (state == IDLE) && cfg_load;
  assign legal = (char_out <= ALPHA_LAST);
  assign stp = (state == STEP) && legal;
  rotor_counter #(.NOTCH(NOTCH1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(cfg_pos1),
    .step_en(stp), .pos(pos1), .at_notch(n1)
  );
  // Middle rotor also steps when it sits on its own notch: the double step.
  rotor_counter #(.NOTCH(NOTCH2)) u_r2 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(cfg_pos2),
    .step_en(stp && (n1 || n2)), .pos(pos2), .at_notch(n2)
  );
  rotor_counter #(.NOTCH(NOTCH3)) u_r3 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(cfg_pos3),
    .step_en(stp && n2), .pos(pos3), .at_notch()
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      char_out <= '0;
      char_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (key_valid && key_ready) begin
          char_out <= key_char;
          state <= STEP;
        end
        STEP: begin
          state <= legal ? OUT : IDLE;
          char_valid <= legal;
        end
        OUT: if (char_ready) begin
          state <= IDLE;
          char_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/rotor_stepper.md
Name: rotor_stepper

Overview:
Per-keystroke rotor position controller that sits directly upstream of the rotor datapath (rotor1_top and the later rotor stages). It accepts one letter at a time. Before the letter is presented, it advances the three rotor positions using Enigma stepping rules, including the middle-rotor double step. It then holds the letter and the new positions stable until the downstream datapath accepts them. It also loads the operator's initial ring positions.

Parameters:
NOTCH1, 21, fast (right, rotor1) turnover position; rotor2 steps when pos1 equals this before stepping.
NOTCH2, 4, middle (rotor2) turnover position; rotor3 steps, and rotor2 double-steps, when pos2 equals this before stepping.
NOTCH3, 16, slow (left, rotor3) notch; carried for completeness, has no stepping effect in a 3-rotor machine.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_load  in  1  load cfg_pos1..3 into the positions (honoured only in IDLE)
cfg_pos1  in  5  initial rotor1 position
cfg_pos2  in  5  initial rotor2 position
cfg_pos3  in  5  initial rotor3 position
key_valid  in  1  key_char is valid
key_ready  out  1  block can accept a key
key_char  in  5  letter code, 0=A .. 25=Z
char_valid  out  1  char_out and pos1..3 are valid for the datapath
char_ready  in  1  datapath accepts the current character
char_out  out  5  registered letter sent to rotor1 data_in
pos1  out  5  rotor1 position, drives the rotor1 position input
pos2  out  5  rotor2 position
pos3  out  5  rotor3 position

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE
  - pos1=pos2=pos3=0, char_out=0, char_valid=0
  - key_ready=1 once rst_n is released
  - asserting reset in any state drops the in-flight character
- FSM states:
  - IDLE: key_ready = !cfg_load. On a cfg_load edge, positions are loaded and state stays IDLE. On a key_valid&key_ready edge, key_char is latched into char_out and state goes to STEP.
  - STEP: exactly one cycle, key_ready=0. Positions update at the end of this cycle, then state goes to OUT.
  - OUT: char_valid=1, key_ready=0. char_out and pos1..3 are held stable until the char_valid&char_ready edge, then state goes to IDLE.
- Latency: key accepted at edge k → updated positions and char_valid=1 visible after edge k+1. Minimum 3 cycles per character with char_ready tied high.
- Stepping (all conditions evaluated on pre-step values, all updates simultaneous):
  - pos1 always increments.
  - pos2 increments if (pos1==NOTCH1) or (pos2==NOTCH2); the second term is the double step.
  - pos3 increments if pos2==NOTCH2.
- Arithmetic: every increment is mod 26 (25→0). Internal incrementer is 5 bits; codes 26..31 are never produced by stepping.
- Out-of-range cfg_pos (26..31) is stored as value−26 (28→2).
- Out-of-range key_char (26..31) is accepted (key_ready handshake completes) and dropped: no step, no char_valid, returns to IDLE after one cycle.
- cfg_load in STEP/OUT is ignored and has no later effect. cfg_load together with key_valid in IDLE: load wins, and the key is not accepted that cycle.
- Outputs are registered, except key_ready, which is decoded from state and cfg_load.

Decomposition:
- enigma_pkg:
  - ALPHA_SIZE=26
  - 5-bit letter type
  - stepper state enum {IDLE, STEP, OUT}
  - notch constants for rotors I–V (Q, E, V, J, Z = 16, 4, 21, 9, 25)
- Sub-module rotor_counter, instantiated 3×:
  - mod-26 register with load (with the −26 fold) and step_en inputs
  - at_notch output, parameterised by NOTCH
  - contains no FSM logic

Test Plan:
1. Assert rst_n=0 mid-OUT, release → pos1..3=0, char_valid=0, key_ready=1; the dropped char never appears.
2. Load (pos3,pos2,pos1)=(0,0,0), key 0 (A), char_ready=1 → char_valid after 2 edges with pos1=1, pos2=0, pos3=0, char_out=0.
3. Double step: load (0,3,20) (A-D-U), send 3 keys → observed positions are (0,3,21) A-D-V, then (0,4,22) A-E-W, then (1,5,23) B-F-X.
4. Wrap: load (25,25,25) with notches not hit, key → pos1=0. Also load pos1=21, pos2=4, pos3=25, key → (0,5,22).
5. Backpressure: char_ready=0 for 5 cycles with key_valid held high → char_valid, char_out and positions are stable, and key_ready=0 throughout. The second key is accepted only after the char_ready edge and IDLE.
6. Illegal inputs: cfg_pos1=28 → pos1=2. key_char=27 → accepted, no step, no char_valid. cfg_load during OUT → positions unchanged.
